xor3_parity_pipe: RTL

Pipelined parity generator/checker built from a three-level XOR3 reduction tree, one register rank per level. Sits directly downstream of the XOR3 cell: the tree's 3-input XOR nodes are its combinational core. It consumes a data word and an optional received parity bit, produces the computed parity and a mismatch flag, and maintains a saturating error count. Streaming valid/ready handshake, one word per cycle.

---
 rtl/xor3_parity_pipe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/xor3_parity_pipe.sv
// Pipelined parity generator/checker: input capture rank, then a three-level XOR3
// reduction tree with one register rank per level, under a single global advance enable.
module xor3_parity_pipe #(
  parameter int WIDTH = 27,
  parameter bit ODD   = 1'b0
) (
  input  logic             CK,
  input  logic             CD,
  input  logic [WIDTH-1:0] DI,
  input  logic             PI,
  input  logic             VI,
  output logic             RI,
  output logic [WIDTH-1:0] DO,
  output logic             PO,
  output logic             PERR,
  output logic             VO,
  input  logic             RO,
  input  logic             CLR,
  output logic [15:0]      ECNT
);

  localparam int TREE_W = 27;

  function automatic logic xor3(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  logic              en;
  logic              xfer;

  logic [WIDTH-1:0]  s0_data;
  logic              s0_pi;
  logic              s0_v;
  logic [TREE_W-1:0] s0_pad;
  logic [8:0]        l1;

  logic [WIDTH-1:0]  s1_data;
  logic [8:0]        s1_part;
  logic              s1_pi;
  logic              s1_v;
  logic [2:0]        l2;

  logic [WIDTH-1:0]  s2_data;
  logic [2:0]        s2_part;
  logic              s2_pi;
  logic              s2_v;
  logic              l3;

  // One enable for every rank: the whole pipe moves or the whole pipe holds.
  assign en   = !VO | RO;
  assign RI   = en;
  assign xfer = VO & RO;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    s0_pad             = '0;
    s0_pad[WIDTH-1:0]  = s0_data;
  end

  always_comb begin
    l1 = '0;
    for (int i = 0; i < 9; i++) begin
      l1[i] = xor3(s0_pad[3*i], s0_pad[3*i+1], s0_pad[3*i+2]);
    end
  end

  always_comb begin
    l2 = '0;
    for (int j = 0; j < 3; j++) begin
      l2[j] = xor3(s1_part[3*j], s1_part[3*j+1], s1_part[3*j+2]);
    end
  end

  assign l3 = xor3(s2_part[0], s2_part[1], s2_part[2]) ^ ODD;

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      // NOTE: datapath registers are reset as well, so DO/PO/PERR read 0 rather than X out of reset.
      s0_data <= '0;
      s0_pi   <= 1'b0;
      s0_v    <= 1'b0;
      s1_data <= '0;
      s1_part <= '0;
      s1_pi   <= 1'b0;
      s1_v    <= 1'b0;
      s2_data <= '0;
      s2_part <= '0;
      s2_pi   <= 1'b0;
      s2_v    <= 1'b0;
      DO      <= '0;
      PO      <= 1'b0;
      PERR    <= 1'b0;
      VO      <= 1'b0;
    end else if (en) begin
      // NOTE: non-blocking assignments make each rank take its predecessor's pre-edge value.
      s0_data <= DI;
      s0_pi   <= PI;
      s0_v    <= VI;
      s1_data <= s0_data;
      s1_part <= l1;
      s1_pi   <= s0_pi;
      s1_v    <= s0_v;
      s2_data <= s1_data;
      s2_part <= l2;
      s2_pi   <= s1_pi;
      s2_v    <= s1_v;
      DO      <= s2_data;
      PO      <= l3;
      PERR    <= l3 ^ s2_pi;
      VO      <= s2_v;
    end
  end

  // Error counter: clear wins over an error transfer on the same edge; saturates at all-ones.
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      ECNT <= '0;
    end else if (CLR) begin
      ECNT <= '0;
    end else if (xfer && PERR && (ECNT != 16'hFFFF)) begin
      ECNT <= ECNT + 16'd1;
    end
  end

endmodule
